// File: rtl/av2_cdef_pkg.sv
// av2_cdef_pkg: shared constants, direction/step table and FSM state type
// for the AV2 CDEF block filter.
package av2_cdef_pkg;

  localparam int PIX_W   = 10;
  localparam int PIX_MAX = 1023;
  localparam int NPIX    = 64;
  localparam int LATENCY = 65;

  // Direction index doubles as the tie-break priority (lowest wins).
  typedef enum logic [1:0] {
    DIR_H    = 2'd0,  // (+1, 0)
    DIR_V    = 2'd1,  // ( 0,+1)
    DIR_D45  = 2'd2,  // (+1,-1)
    DIR_D135 = 2'd3   // (+1,+1)
  } cdef_dir_e;

  localparam int DIR_DX [4] = '{1, 0,  1, 1};
  localparam int DIR_DY [4] = '{0, 1, -1, 1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIR    = 2'd1,
    ST_FILTER = 2'd2,
    ST_DONE   = 2'd3
  } cdef_state_e;

  // floor(log2(v)); v = 0 maps to 0 (only reached when strength is 0).
  function automatic logic [2:0] floor_log2(input logic [4:0] v);
    logic [2:0] r;
    if (v[4])      r = 3'd4;
    else if (v[3]) r = 3'd3;
    else if (v[2]) r = 3'd2;
    else if (v[1]) r = 3'd1;
    else           r = 3'd0;
    return r;
  endfunction

endpackage

// File: rtl/av2_cdef_constrain.sv
// av2_cdef_constrain: combinational CDEF primary constrain function,
// c = sign(d) * min(|d|, max(0, s - (|d| >> sh))).
module av2_cdef_constrain (
  input  logic signed [11:0] d,
  input  logic        [4:0]  s,
  input  logic        [3:0]  sh,
  output logic signed [11:0] c
);

  logic [11:0] mag_d;
  logic [11:0] shifted;
  logic [11:0] s_ext;
  logic [11:0] lim;
  logic [11:0] mag;

  // Magnitude limit shrinks as the difference grows; large edges get 0.
  always_comb begin
    mag_d   = d[11] ? (~d + 12'd1) : d;
    shifted = mag_d >> sh;
    s_ext   = {7'b0, s};
    lim     = (s_ext > shifted) ? (s_ext - shifted) : 12'd0;
    mag     = (mag_d < lim) ? mag_d : lim;
    c       = d[11] ? $signed(~mag + 12'd1) : $signed(mag);
  end

endmodule

// File: rtl/av2_cdef_filter.sv
// av2_cdef_filter: captures one 8x8 block, picks an edge direction, then
// filters one pixel per clock along it. Define CDEF_DIR_SEARCH_EN to enable
// the direction search; otherwise the direction is fixed to horizontal.
module av2_cdef_filter
  import av2_cdef_pkg::*;
#(
  parameter int BLOCK_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PIX_W-1:0]  src_block [0:NPIX-1],
  input  logic [2:0]        strength_y,
  input  logic [2:0]        strength_uv,
  input  logic [2:0]        damping,
  input  logic              is_chroma,
  input  logic              ready,
  output logic [PIX_W-1:0]  dst_block [0:NPIX-1],
  output logic              valid,
  output cdef_state_e       dbg_state,
  output cdef_dir_e         dbg_dir
);

  // Handshake: in IDLE, ready=1 starts a job; valid=1 marks a finished block
  // held on dst_block, and ready=1 while valid acknowledges it (valid drops on
  // that edge) without starting another job.

  localparam int TAP_OFF [4] = '{-1, 1, -2, 2};

  cdef_state_e      state_q, state_d;
  cdef_dir_e        dir_q, dir_d, dir_sel;
  logic [5:0]       idx_q, idx_d;
  logic [2:0]       str_q, str_d;
  logic [2:0]       damp_q, damp_d;
  logic             valid_q, valid_d;
  logic [PIX_W-1:0] blk_q [0:NPIX-1];
  logic [PIX_W-1:0] blk_d [0:NPIX-1];
  logic [PIX_W-1:0] dst_q [0:NPIX-1];
  logic [PIX_W-1:0] dst_d [0:NPIX-1];

  logic [4:0]         s_eff;
  logic [2:0]         lg;
  logic [3:0]         sh;
  logic [PIX_W-1:0]   x_pix;
  logic [PIX_W-1:0]   tap_v [4];
  logic               tap_ok [4];
  logic signed [11:0] tap_d [4];
  logic signed [11:0] tap_c [4];
  logic [PIX_W-1:0]   y_pix;

`ifdef CDEF_DIR_SEARCH_EN
  logic [16:0] cost [4];

  // Sum of absolute neighbour differences per direction; smallest cost wins.
  always_comb begin
    int nx, ny;
    logic [PIX_W-1:0] a, b;
    logic [16:0] best;
    for (int d = 0; d < 4; d++) cost[2'(d)] = '0;
    for (int y = 0; y < BLOCK_SIZE; y++) begin
      for (int x = 0; x < BLOCK_SIZE; x++) begin
        for (int d = 0; d < 4; d++) begin
          nx = x + DIR_DX[2'(d)];
          ny = y + DIR_DY[2'(d)];
          if (nx >= 0 && nx < BLOCK_SIZE && ny >= 0 && ny < BLOCK_SIZE) begin
            a = blk_q[6'(y * BLOCK_SIZE + x)];
            b = blk_q[6'(ny * BLOCK_SIZE + nx)];
            cost[2'(d)] = cost[2'(d)] + 17'((a > b) ? (a - b) : (b - a));
          end
        end
      end
    end
    dir_sel = DIR_H;
    best    = cost[0];
    for (int d = 1; d < 4; d++) begin
      if (cost[2'(d)] < best) begin
        best    = cost[2'(d)];
        dir_sel = cdef_dir_e'(2'(d));
      end
    end
  end
`else
  assign dir_sel = DIR_H;
`endif

  // Effective strength and damping shift for the captured job.
  always_comb begin
    s_eff = {str_q, 2'b00};
    lg    = floor_log2(s_eff);
    if (({2'b00, damp_q} + 5'd2) > {2'b00, lg})
      sh = 4'({2'b00, damp_q} + 5'd2 - {2'b00, lg});
    else
      sh = 4'd0;
  end

  // Tap gathering; taps leaving the block read the centre pixel so d = 0.
  always_comb begin
    int cx, cy, tx, ty;
    cx    = int'(idx_q) % BLOCK_SIZE;
    cy    = int'(idx_q) / BLOCK_SIZE;
    x_pix = blk_q[idx_q];
    for (int k = 0; k < 4; k++) begin
      tx = cx + TAP_OFF[2'(k)] * DIR_DX[dir_q];
      ty = cy + TAP_OFF[2'(k)] * DIR_DY[dir_q];
      tap_ok[2'(k)] = (tx >= 0) && (tx < BLOCK_SIZE) && (ty >= 0) && (ty < BLOCK_SIZE);
      tap_v[2'(k)]  = tap_ok[2'(k)] ? blk_q[6'(ty * BLOCK_SIZE + tx)] : x_pix;
      tap_d[2'(k)]  = 12'($signed({2'b00, tap_v[2'(k)]}) - $signed({2'b00, x_pix}));
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_con
    av2_cdef_constrain u_con (
      .d  (tap_d[g]),
      .s  (s_eff),
      .sh (sh),
      .c  (tap_c[g])
    );
  end

  // Weighted sum, rounding toward zero-biased nearest, clamp to tap range.
  always_comb begin
    logic signed [12:0] sum, ext, rnd, y_s, mn, mx;
    sum = '0;
    mn  = {3'b000, x_pix};
    mx  = {3'b000, x_pix};
    for (int k = 0; k < 4; k++) begin
      ext = 13'(tap_c[2'(k)]);
      sum = sum + ((k < 2) ? (ext <<< 2) : (ext <<< 1));
      if (tap_ok[2'(k)]) begin
        if ($signed({3'b000, tap_v[2'(k)]}) < mn) mn = {3'b000, tap_v[2'(k)]};
        if ($signed({3'b000, tap_v[2'(k)]}) > mx) mx = {3'b000, tap_v[2'(k)]};
      end
    end
    rnd = sum + 13'sd8 - ((sum < 13'sd0) ? 13'sd1 : 13'sd0);
    y_s = $signed({3'b000, x_pix}) + (rnd >>> 4);
    if (y_s < mn) y_s = mn;
    if (y_s > mx) y_s = mx;
    if (y_s < 13'sd0) y_s = 13'sd0;
    if (y_s > 13'(PIX_MAX)) y_s = 13'(PIX_MAX);
    y_pix = (str_q == 3'd0) ? x_pix : y_s[PIX_W-1:0];
  end

  // Next-state logic for the IDLE -> DIR -> FILTER -> DONE job sequence.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    str_d   = str_q;
    damp_d  = damp_q;
    valid_d = valid_q;
    blk_d   = blk_q;
    dst_d   = dst_q;
    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          blk_d   = src_block;
          str_d   = is_chroma ? strength_uv : strength_y;
          damp_d  = damping;
          state_d = ST_DIR;
        end
      end
      ST_DIR: begin
        dir_d   = dir_sel;
        idx_d   = 6'd0;
        state_d = ST_FILTER;
      end
      ST_FILTER: begin
        dst_d[idx_q] = y_pix;
        idx_d        = idx_q + 6'd1;
        if (idx_q == 6'(NPIX - 1)) begin
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Single state register; reset aborts any job and clears the output block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_H;
      idx_q   <= '0;
      str_q   <= '0;
      damp_q  <= '0;
      valid_q <= 1'b0;
      blk_q   <= '{default: '0};
      dst_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      str_q   <= str_d;
      damp_q  <= damp_d;
      valid_q <= valid_d;
      blk_q   <= blk_d;
      dst_q   <= dst_d;
    end
  end

  assign dst_block = dst_q;
  assign valid     = valid_q;
  assign dbg_state = state_q;
  assign dbg_dir   = dir_q;

endmodule

// File: tb/tb_av2_cdef_filter.sv
// tb_av2_cdef_filter: directed bench for av2_cdef_filter with hand-computed
// expected pixels, latency and handshake behaviour.
module tb_av2_cdef_filter;
  import av2_cdef_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  src [0:63];
  logic [9:0]  dst [0:63];
  logic [2:0]  strength_y, strength_uv, damping;
  logic        is_chroma, ready, valid;
  cdef_state_e dbg_state;
  cdef_dir_e   dbg_dir;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  av2_cdef_filter #(.BLOCK_SIZE(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_block   (src),
    .strength_y  (strength_y),
    .strength_uv (strength_uv),
    .damping     (damping),
    .is_chroma   (is_chroma),
    .ready       (ready),
    .dst_block   (dst),
    .valid       (valid),
    .dbg_state   (dbg_state),
    .dbg_dir     (dbg_dir)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic fill_flat(input logic [9:0] v);
    for (int i = 0; i < 64; i++) src[i] = v;
  endtask

  task automatic start_job();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic ack();
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic wait_valid(input int start, output int n);
    n = start;
    while (valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [1:0] exp_dir_edge;
`ifdef CDEF_DIR_SEARCH_EN
    exp_dir_edge = 2'd1;
`else
    exp_dir_edge = 2'd0;
`endif
    ready = 1'b0; is_chroma = 1'b0;
    strength_y = 3'd0; strength_uv = 3'd0; damping = 3'd0;
    fill_flat(10'd0);

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_dst0", dst[0], 0);
    check("rst_dst63", dst[63], 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // flat 128, strength 0
    fill_flat(10'd128);
    start_job();
    wait_valid(0, n);
    check("flat_latency", n, 65);
    for (int i = 0; i < 64; i++) check($sformatf("flat_dst%0d", i), dst[i], 128);
    ack();
    check("flat_ack_valid", valid, 0);
    repeat (3) @(posedge clk);
    #1;
    check("flat_no_restart", dbg_state, ST_IDLE);
    check("flat_valid_low", valid, 0);
    for (int i = 0; i < 64; i += 9) check($sformatf("flat_hold%0d", i), dst[i], 128);

    // vertical edge; inputs scrambled after capture
    for (int i = 0; i < 64; i++) src[i] = ((i % 8) < 4) ? 10'd50 : 10'd200;
    strength_y = 3'd3; damping = 3'd2; is_chroma = 1'b0;
    start_job();
    check("edge_state_dir", dbg_state, ST_DIR);
    check("edge_hold_cap", dst[0], 128);
    @(posedge clk); #1;
    check("edge_state_filt", dbg_state, ST_FILTER);
    check("edge_hold_dir", dst[0], 128);
    fill_flat(10'd999); strength_y = 3'd7; strength_uv = 3'd7; damping = 3'd0; is_chroma = 1'b1;
    wait_valid(1, n);
    check("edge_latency", n, 65);
    check("edge_dir", dbg_dir, exp_dir_edge);
    check("edge_dst3", dst[3], 50);
    check("edge_dst4", dst[4], 200);
    for (int i = 0; i < 64; i++)
      check($sformatf("edge_dst%0d", i), dst[i], ((i % 8) < 4) ? 50 : 200);
    ack();

    // impulse, strength 1, damping 7
    fill_flat(10'd128); src[27] = 10'd160;
    is_chroma = 1'b0; strength_y = 3'd1; strength_uv = 3'd0; damping = 3'd7;
    start_job();
    wait_valid(0, n);
    check("imp_latency", n, 65);
    check("imp_dir", dbg_dir, 0);
    check("imp_dst27", dst[27], 157);
    check("imp_dst26", dst[26], 129);
    check("imp_dst28", dst[28], 129);
    check("imp_dst25", dst[25], 129);
    check("imp_dst29", dst[29], 129);
    check("imp_dst19", dst[19], 128);
    check("imp_dst0", dst[0], 128);
    repeat (2) @(posedge clk);
    #1;
    check("imp_valid_hold", valid, 1);
    ack();

    // impulse, damping 0: every constrain is 0
    damping = 3'd0;
    start_job();
    wait_valid(0, n);
    check("d0_dst27", dst[27], 160);
    check("d0_dst26", dst[26], 128);
    check("d0_dst28", dst[28], 128);
    ack();

    // chroma selects strength_uv
    is_chroma = 1'b1; strength_uv = 3'd1; strength_y = 3'd0; damping = 3'd7;
    start_job();
    wait_valid(0, n);
    check("uv_dst27", dst[27], 157);
    check("uv_dst26", dst[26], 129);
    ack();
    is_chroma = 1'b0;
    start_job();
    wait_valid(0, n);
    check("y0_dst27", dst[27], 160);
    check("y0_dst26", dst[26], 128);
    ack();

    // reset during FILTER
    is_chroma = 1'b1;
    start_job();
    repeat (30) @(posedge clk);
    #1;
    check("mid_state", dbg_state, ST_FILTER);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_dst0", dst[0], 0);
    check("mid_rst_dst27", dst[27], 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_job();
    wait_valid(0, n);
    check("rerun_latency", n, 65);
    check("rerun_dst27", dst[27], 157);
    check("rerun_dst26", dst[26], 129);
    ack();
    check("rerun_ack", valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/av2_cdef_filter.md
# av2_cdef_filter

Constrained directional enhancement filter (CDEF) for one 8x8 block of 10-bit samples in the AV2 in-loop filter chain, placed after deblocking and before loop restoration. It captures a block, estimates the dominant edge direction, then applies a primary-only constrained low-pass filter along that direction. The filtered block is held on `dst_block` until the next job.

## Interface
- `BLOCK_SIZE`, default 8: block edge length. Only 8 is supported, giving 64 pixels.
- `clk` in 1: clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_block[0:63]` in 10 each: unpacked array, raster order, index = y*8+x.
- `strength_y` in 3: luma primary strength.
- `strength_uv` in 3: chroma primary strength.
- `damping` in 3: damping control.
- `is_chroma` in 1: 1 selects `strength_uv`, 0 selects `strength_y`.
- `ready` in 1: start strobe when idle; acknowledge when done.
- `dst_block[0:63]` out 10 each: registered filtered block.
- `valid` out 1: registered; high while a result is pending acknowledge.

## Operation
- FSM states: IDLE, DIR, FILTER, DONE.
- IDLE: on `ready`=1, capture all inputs (block, selected strength, damping), go to DIR.
- DIR, 1 cycle: compute four costs. Each cost is the sum of |a−b| over all in-block pixel pairs (p, p+step).
  - Steps: dir0 (+1,0) horizontal; dir1 (0,+1) vertical; dir2 (+1,−1); dir3 (+1,+1).
  - Select the minimum cost. Ties go to the lowest index. Go to FILTER.
- FILTER: one pixel per cycle, index 0..63.
  - For pixel x, the taps are p±1·step (weight 4) and p±2·step (weight 2).
  - Taps outside the block are dropped: they contribute 0 and are excluded from the clamp.
- Effective strength S = strength<<2. Shift sh = max(0, damping+2 − floor(log2 S)).
- constrain(d) = sign(d)·min(|d|, max(0, S − (|d|>>sh))). Here d = tap − x, as a signed 12-bit value.
- sum = Σ weight·constrain(d), as a signed 12-bit value or wider.
- y = x + ((8 + sum − (sum<0)) >>> 4), using an arithmetic shift.
- y is then clamped to [min, max] of x and the valid taps, then to [0,1023].
- strength = 0 → y = x. The FSM path is unchanged.
- After pixel 63 go to DONE and set `valid`=1.
- DONE: `ready`=1 clears `valid` and returns to IDLE. It does not start a new job; a new job needs a fresh `ready` pulse while in IDLE.
- Input changes after capture have no effect on the running job.

## Timing
- Reset values: `valid`=0, all `dst_block`=0, state IDLE.
- Reset mid-job aborts to IDLE. A partially written `dst_block` is cleared to 0.
- Latency: `valid` rises 65 clocks after the capture edge (1 DIR + 64 FILTER).
- `dst_block[i]` updates in FILTER cycle i.
- `dst_block` is stable from `valid` rising until the next job's FILTER begins. It stays stable after acknowledge.
- `valid` drops on the edge that samples `ready`=1 in DONE.
- Throughput: one block per 67 clocks minimum.

## Configuration
- `CDEF_DIR_SEARCH_EN` defined: direction search as specified.
- Undefined: cost logic is omitted and the direction is fixed to dir0 (horizontal). The DIR cycle is kept so latency is identical.

## Structure
- Package `av2_cdef_pkg` holds:
  - constants PIX_W=10, PIX_MAX=1023, NPIX=64, LATENCY=65
  - the direction enum and the direction step table
  - the FSM state typedef
- Sub-module `av2_cdef_constrain`: combinational constrain(d, S, sh). Instantiated 4 times, once per tap.

## Test plan
- Flat 128 block, strength 0, damping 0 → `valid` after 65 clocks; all outputs 128; outputs still 128 after acknowledge.
- Edge block (columns 0–3 = 50, columns 4–7 = 200), strength_y=3, damping=2 → dir1 chosen; `dst[3]`=50, `dst[4]`=200, and the block is unchanged.
- Flat 128 with `src[27]`=160, strength_y=1, damping=7, dir0 (costs tie at 64) → `dst[27]`=157, `dst[26]`=129, `dst[28]`=129, `dst[0]`=128.
- Same impulse with damping=0 → sh=0, so all constrains are 0; output equals input.
- Chroma select: impulse, `is_chroma`=1, strength_uv=1, strength_y=0, damping=7 → `dst[27]`=157. With `is_chroma`=0 and the same strengths → 160.
- Reset asserted during FILTER → `valid`=0 and `dst`=0 immediately; the next `ready` pulse runs a full 65-clock job.
